// File: rtl/lfsr_rng_gen.sv
// Pseudo-random source for cactus spawn selection: Galois LFSR stepped by a
// free-running prescaler, with one-shot button entropy capture, explicit
// seeding, zero-state lockout and a one-cycle valid strobe.
module lfsr_rng_gen #(
  parameter int unsigned             WIDTH    = 16,
  parameter logic [WIDTH-1:0]        TAPS     = 16'hB400,
  parameter logic [WIDTH-1:0]        SEED     = WIDTH'(1),
  parameter int unsigned             PRESCALE = 753750,
  parameter int unsigned             OUT_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic              mode,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed_in,
  output logic [OUT_W-1:0]  random,
  output logic              random_valid,
  output logic [WIDTH-1:0]  lfsr_state,
  output logic              entropy_latched
);

  localparam int unsigned     PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             btn_prev_q, btn_prev_d;
  logic             entropy_q, entropy_d;
  logic             valid_q, valid_d;

  logic             tick;
  logic             step;
  logic             rise;
  logic [WIDTH-1:0] galois_next;
  logic [WIDTH-1:0] capture_x;

  // Next-state: prescaler, button edge, and the prioritised LFSR action
  always_comb begin
    lfsr_d     = lfsr_q;
    entropy_d  = entropy_q;
    valid_d    = 1'b0;
    btn_prev_d = button;

    tick        = (pre_cnt_q == PRE_LAST);
    step        = tick & (mode | button);
    rise        = button & ~btn_prev_q;
    pre_cnt_d   = tick ? '0 : pre_cnt_q + PRE_W'(1);
    galois_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    capture_x   = lfsr_q ^ WIDTH'(pre_cnt_q);

    // Only one action per cycle; a step losing priority is simply dropped
    if (seed_load) begin
      lfsr_d    = (seed_in == '0) ? SEED : seed_in;
      entropy_d = 1'b1;
      valid_d   = 1'b1;
    end else if (rise && !entropy_q) begin
      lfsr_d    = (capture_x == '0) ? SEED : capture_x;
      entropy_d = 1'b1;
      valid_d   = 1'b1;
    end else if (step) begin
      lfsr_d    = (galois_next == '0) ? SEED : galois_next;
      valid_d   = 1'b1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q     <= SEED;
      pre_cnt_q  <= '0;
      btn_prev_q <= 1'b0;
      entropy_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      pre_cnt_q  <= pre_cnt_d;
      btn_prev_q <= btn_prev_d;
      entropy_q  <= entropy_d;
      valid_q    <= valid_d;
    end
  end

  assign lfsr_state      = lfsr_q;
  assign random          = lfsr_q[OUT_W-1:0];
  assign random_valid    = valid_q;
  assign entropy_latched = entropy_q;

endmodule

// File: doc/lfsr_rng_gen.md
Name: lfsr_rng_gen

Overview:
Parametrised pseudo-random source for obstacle (cactus) spawn selection in the Dino game datapath. It uses a Galois LFSR of configurable width and taps, stepped by a free-running prescaler. The LFSR advances either while the jump button is held (legacy mode) or continuously (free-run mode). It adds a one-shot entropy capture from the first button press, explicit seeding, zero-state lockout protection and a valid strobe for downstream spawn logic.

Parameters:
WIDTH, 16, LFSR state width in bits (2..32)
TAPS, 16'hB400, Galois feedback mask, WIDTH bits; default is maximal length (period 65535)
SEED, 1, reset and fallback state; must be nonzero
PRESCALE, 753750, clk cycles per step tick (>=1)
OUT_W, 5, width of random output (1..WIDTH)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
button  in  1  jump button, already synchronised to clk
mode  in  1  0 = step only while button high; 1 = free-run
seed_load  in  1  single-cycle request to load seed_in
seed_in  in  WIDTH  seed value
random  out  OUT_W  current random value, equal to lfsr_state[OUT_W-1:0]
random_valid  out  1  one-cycle pulse when random holds a new value
lfsr_state  out  WIDTH  full LFSR state, for debug and verification
entropy_latched  out  1  high once a seed or entropy capture has occurred

Behaviour:
- Interface: one clock, clk. Reset is rst, synchronous and active-high. All state changes on posedge clk only.
- Reset (rst=1 at an edge) sets:
  - lfsr_state=SEED, random=SEED[OUT_W-1:0], random_valid=0
  - pre_cnt=0, entropy_latched=0, button_d=0
  - Reset overrides every other input in the same cycle.
- Prescaler:
  - pre_cnt has width clog2(PRESCALE) (minimum 1). It counts 0..PRESCALE-1, then wraps to 0.
  - It free-runs regardless of button and mode.
  - tick=1 in the cycle where pre_cnt==PRESCALE-1. With PRESCALE=1, tick=1 every cycle.
- Step condition: step = tick & (mode | button).
- Galois step, next = (s>>1) ^ (s[0] ? TAPS : 0).
- Button edge: button_d registers button. rise = button & ~button_d.
- Entropy capture:
  - Triggered when rise=1 and entropy_latched=0.
  - x = lfsr_state ^ pre_cnt (pre_cnt zero-extended or truncated to WIDTH). lfsr_state = (x==0) ? SEED : x.
  - entropy_latched is set to 1. This happens once per reset.
- Seed load: lfsr_state = (seed_in==0) ? SEED : seed_in, and entropy_latched is set to 1. A later button rise therefore performs no capture, which makes runs deterministic.
- Per-cycle priority: rst > seed_load > entropy capture > step. Only one action applies per cycle. A step that loses priority is dropped, not deferred.
- Outputs:
  - random is updated on the same edge as lfsr_state, for every action (seed, capture, step).
  - random_valid=1 in the cycle after an edge that performed a step, capture or seed load; otherwise 0.
  - Latency: state change at edge N, random and random_valid visible from edge N.
- Zero lockout: lfsr_state never holds 0. Any path that would produce 0 loads SEED instead. A Galois step from a nonzero state with a valid TAPS cannot produce 0.
- Button released mid-period (mode=0): no step at that tick; the prescaler continues; no state change.
- mode changing mid-period takes effect at the next tick; the prescaler is not reset.

Test Plan:
1. Bench parameters WIDTH=5, TAPS=5'h14, SEED=1, PRESCALE=4, OUT_W=5. rst, then seed_load seed_in=1, mode=0, button held high → random_valid pulses every 4 cycles; random sequence 0x14, 0x0A, 0x05, 0x16, 0x0B, 0x11; state returns to 0x01 after exactly 31 steps.
2. Same setup, button low for 12 cycles → no random_valid; lfsr_state unchanged; pre_cnt wraps 3 times.
3. rst, mode=1, button=0 → steps every 4 cycles without button. With button rising when pre_cnt=2 and entropy_latched=0 → state=0x01^0x02=0x03, entropy_latched=1, one valid pulse. A second button rise → no capture.
4. seed_load asserted with seed_in=0 on a tick cycle with button high → state=SEED (0x01), step dropped, exactly one valid pulse. seed_in=0x1F → state 0x1F, next step gives 0x1B.
5. rst asserted mid-sequence, simultaneously with seed_load and a tick → lfsr_state=0x01, random_valid=0, pre_cnt=0, entropy_latched=0.
6. Default parameters (WIDTH=16, TAPS=16'hB400, PRESCALE=1, mode=1) → state sequence from 0x0001 is 0xB400, 0x5A00, 0x2D00; period 65535 with no zero state.
